quad_step_encoder: RTL and testbench
====================================

QUAD_STEP_ENCODER -- requirements
Module: quad_step_encoder

Interface
REQ-001 SHALL have parameter PHASE_TICKS, default 4, clk cycles each quadrature phase is held (legal range >= 1).
REQ-002 SHALL have parameter CNT_W, default 8, width of the detent count field.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port cmd_valid  input  1  command present.
REQ-006 SHALL have port cmd_up  input  1  direction: 1 = count up (a leads b), 0 = down (b leads a).
REQ-007 SHALL have port cmd_count  input  CNT_W  number of detents to emit.
REQ-008 SHALL have port cmd_ready  output  1  block can accept a command.
REQ-009 SHALL have port a  output  1  quadrature channel A, registered.
REQ-010 SHALL have port b  output  1  quadrature channel B, registered.
REQ-011 SHALL have port busy  output  1  high while a command is in progress, including the trailing gap.
REQ-012 SHALL have port done  output  1  single-cycle pulse on command completion.
REQ-013 SHALL have port steps_left  output  CNT_W  detents remaining, including the one in progress.

Function
REQ-014 SHALL implement states IDLE, RUN, GAP; cmd_ready = 1 only in IDLE; busy = 1 in RUN and GAP.
REQ-015 SHALL accept a command on a rising edge with cmd_valid && cmd_ready, latching cmd_up and cmd_count.
REQ-016 SHALL, on accepting cmd_count = 0, leave a,b unchanged, pulse done in the following cycle, and remain in IDLE.
REQ-017 SHALL, on accepting cmd_count > 0, enter RUN and load steps_left = cmd_count.
REQ-018 SHALL use up sequence {a,b}: 00 -> 10 -> 11 -> 01 -> 00, and down sequence: 00 -> 01 -> 11 -> 10 -> 00.
REQ-019 SHALL treat one detent as 4 transitions ending at rest code 00.
REQ-020 SHALL change at most one of a,b per clock edge (Gray property).
REQ-021 SHALL make the first transition exactly PHASE_TICKS cycles after the accepting edge, and each subsequent transition PHASE_TICKS cycles after the previous one.
REQ-022 SHALL decrement steps_left on the edge that returns {a,b} to 00.
REQ-023 SHALL, on the final return to 00, assert done for that one cycle and enter GAP.
REQ-024 SHALL hold {a,b} = 00 for PHASE_TICKS cycles in GAP, then return to IDLE with cmd_ready = 1.
REQ-025 SHALL ignore cmd_valid and keep the latched direction and count stable while busy.
REQ-026 SHALL, with PHASE_TICKS = 1, transition on every cycle in RUN.
REQ-027 SHALL wrap nothing: steps_left never underflows, and maximum count 2^CNT_W-1 runs to completion.

Reset
REQ-028 SHALL, on rst asserted, immediately force state = IDLE, a = 0, b = 0, busy = 0, done = 0, steps_left = 0, phase timer = 0; cmd_ready = 1 after rst deasserts.
REQ-029 SHALL permit reset mid-RUN; the resulting possible double transition (e.g. 11 -> 00) is accepted and no done pulse is issued.

Structure
REQ-030 SHALL take state encodings and the quadrature codes (REST=00, A_ONLY=10, BOTH=11, B_ONLY=01) from shared package quad_pkg, which is also used by the decoder side.
REQ-031 SHALL place the PHASE_TICKS down-counter in one sub-module, phase_timer, with load, tick-out, clk and rst.

Verification
REQ-032 SHALL cover: PHASE_TICKS=4, up, count 1 accepted at cycle 0 -> {a,b} = 10@4, 11@8, 01@12, 00@16; done@16; cmd_ready@20.
REQ-033 SHALL cover: down, count 2 -> 01,11,10,00,01,11,10,00 at 4-cycle spacing; steps_left 2 -> 1@16 -> 0@32.
REQ-034 SHALL cover: count 0 -> no edge on a or b; done one cycle after accept; busy never high.
REQ-035 SHALL cover: cmd_valid held high with a new cmd_count while busy -> ignored; second command accepted only at first cmd_ready.
REQ-036 SHALL cover: rst asserted at cycle 9 during up run ({a,b}=11) -> a=b=0 immediately, no done; a new command after release behaves as in REQ-032.
REQ-037 SHALL cover: loopback into ose_decoder_fsm, count 5 up then 5 down -> decoder cnten pulses 10 times, up=1 for the first 5 and up=0 for the last 5, one dirch; bench checks the Gray property on every cycle.

Source files
------------

// File: rtl/quad_pkg.sv
// -----------------------------------------------------------------------------
// quad_pkg
// Shared definitions for the quadrature step encoder and its decoder
// counterpart. It holds the controller state encoding, the four quadrature
// codes {a,b}, and a helper that maps a phase index and a direction to a code.
// No ports (package).
// -----------------------------------------------------------------------------
package quad_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_GAP  = 2'd2
   } quad_state_e;

   // Quadrature codes, written as {a,b}
   localparam logic [1:0] REST   = 2'b00;
   localparam logic [1:0] A_ONLY = 2'b10;
   localparam logic [1:0] BOTH   = 2'b11;
   localparam logic [1:0] B_ONLY = 2'b01;

   // Phase 0 is the rest code. Phases 1..3 walk the Gray cycle in the
   // requested direction: up = a leads b, down = b leads a.
   function automatic logic [1:0] quad_code(input logic [1:0] phase,
                                            input logic       up);
      logic [1:0] code;
      case (phase)
         2'd0:    code = REST;
         2'd1:    code = up ? A_ONLY : B_ONLY;
         2'd2:    code = BOTH;
         2'd3:    code = up ? B_ONLY : A_ONLY;
         default: code = REST;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/phase_timer.sv
// -----------------------------------------------------------------------------
// phase_timer
// Free-running PHASE_TICKS down-counter that paces the quadrature phases.
// tick is high in the cycle where the count has reached zero. The counter
// reloads on that tick, so consecutive ticks are PHASE_TICKS cycles apart.
// Asserting load restarts a full period, so the next tick comes exactly
// PHASE_TICKS edges after the loading edge.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset (count cleared to zero)
//   load : restart the period on this edge
//   tick : period elapsed (combinational decode of the count register)
// -----------------------------------------------------------------------------
module phase_timer #(
   parameter int PHASE_TICKS = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic tick
);

   localparam int TW = (PHASE_TICKS > 1) ? $clog2(PHASE_TICKS) : 1;
   localparam logic [TW-1:0] RELOAD = TW'(PHASE_TICKS - 1);
   localparam logic [TW-1:0] ZERO   = {TW{1'b0}};
   localparam logic [TW-1:0] ONE    = TW'(1);

   logic [TW-1:0] cnt_r;

   assign tick = (cnt_r == ZERO);

   // Down-count with reload on expiry or explicit restart
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= ZERO;
      end else if (load || (cnt_r == ZERO)) begin
         cnt_r <= RELOAD;
      end else begin
         cnt_r <= cnt_r - ONE;
      end
   end

endmodule

// File: rtl/quad_step_encoder.sv
// -----------------------------------------------------------------------------
// quad_step_encoder
// Emits a burst of quadrature detents on a,b in response to a command. Each
// detent is four Gray transitions that end at the rest code 00. Transitions
// are PHASE_TICKS cycles apart. After the last detent the outputs stay at rest
// for one more PHASE_TICKS gap before a new command can be accepted.
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   cmd_valid  : command present
//   cmd_up     : 1 = up (a leads b), 0 = down (b leads a)
//   cmd_count  : number of detents to emit
//   cmd_ready  : ready to accept a command (IDLE only)
//   a, b       : quadrature outputs, registered
//   busy       : command in progress, trailing gap included
//   done       : one-cycle pulse on completion
//   steps_left : detents remaining, including the one in progress
// -----------------------------------------------------------------------------
module quad_step_encoder
   import quad_pkg::*;
#(
   parameter int PHASE_TICKS = 4,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   input  logic             cmd_up,
   input  logic [CNT_W-1:0] cmd_count,
   output logic             cmd_ready,
   output logic             a,
   output logic             b,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] steps_left
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

   quad_state_e      state_r, state_s;
   logic [1:0]       phase_r, phase_s;
   logic             up_r, up_s;
   logic [CNT_W-1:0] steps_r, steps_s;
   logic             a_r, b_r;
   logic             done_r, done_s;
   logic             busy_r, ready_r;
   logic             load_s;
   logic             tick_s;
   logic [1:0]       ab_s;

   phase_timer #(
      .PHASE_TICKS (PHASE_TICKS)
   ) u_phase_timer (
      .clk  (clk),
      .rst  (rst),
      .load (load_s),
      .tick (tick_s)
   );

   // Next-state, latched command and next quadrature code
   always_comb begin
      state_s = state_r;
      phase_s = phase_r;
      up_s    = up_r;
      steps_s = steps_r;
      done_s  = 1'b0;
      load_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (cmd_valid) begin
               up_s    = cmd_up;
               steps_s = cmd_count;
               load_s  = 1'b1;
               // An empty command completes at once without moving a,b
               if (cmd_count == CNT_ZERO) begin
                  done_s = 1'b1;
               end else begin
                  state_s = ST_RUN;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (tick_s) begin
               phase_s = phase_r + 2'd1;
               // Phase 3 -> 0 is the return to rest that closes a detent
               if (phase_r == 2'd3) begin
                  steps_s = steps_r - CNT_ONE;
                  if (steps_r == CNT_ONE) begin
                     done_s  = 1'b1;
                     state_s = ST_GAP;
                  end else begin
                     state_s = ST_RUN;
                  end
               end else begin
                  state_s = ST_RUN;
               end
            end else begin
               state_s = ST_RUN;
            end
         end
         ST_GAP: begin
            if (tick_s) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_GAP;
            end
         end
         default: begin
            state_s = ST_IDLE;
            phase_s = 2'd0;
         end
      endcase
      ab_s = quad_code(phase_s, up_s);
   end

   // Controller state and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
         phase_r <= 2'd0;
         up_r    <= 1'b0;
         steps_r <= CNT_ZERO;
         a_r     <= 1'b0;
         b_r     <= 1'b0;
         done_r  <= 1'b0;
         busy_r  <= 1'b0;
         ready_r <= 1'b1;
      end else begin
         state_r <= state_s;
         phase_r <= phase_s;
         up_r    <= up_s;
         steps_r <= steps_s;
         a_r     <= ab_s[1];
         b_r     <= ab_s[0];
         done_r  <= done_s;
         busy_r  <= (state_s != ST_IDLE);
         ready_r <= (state_s == ST_IDLE);
      end
   end

   assign cmd_ready  = ready_r;
   assign a          = a_r;
   assign b          = b_r;
   assign busy       = busy_r;
   assign done       = done_r;
   assign steps_left = steps_r;

endmodule

// File: tb/tb_quad_step_encoder.sv
// -----------------------------------------------------------------------------
// tb_quad_step_encoder
// Directed self-checking bench for quad_step_encoder at its default
// parameters (PHASE_TICKS = 4, CNT_W = 8). A small behavioural decoder
// watches a,b on every falling edge. It checks that the outputs never change
// both bits at once, and it counts detents and direction changes.
// -----------------------------------------------------------------------------
module tb_quad_step_encoder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_up = 1'b0;
   logic [7:0] cmd_count = 8'd0;
   logic       cmd_ready;
   logic       a, b;
   logic       busy, done;
   logic [7:0] steps_left;

   int n_checks = 0;
   int n_pass   = 0;

   // Expected {a,b} per phase index, taken straight from the sequences
   logic [1:0] up_seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
   logic [1:0] dn_seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

   // Decoder model state
   logic [1:0]  prev_ab = 2'b00;
   int          dec_up = 0;
   int          dec_dn = 0;
   int          dec_dirch = 0;
   logic        have_dir = 1'b0;
   logic        last_dir = 1'b0;
   logic [15:0] dec_seq = 16'd0;

   quad_step_encoder dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_up     (cmd_up),
      .cmd_count  (cmd_count),
      .cmd_ready  (cmd_ready),
      .a          (a),
      .b          (b),
      .busy       (busy),
      .done       (done),
      .steps_left (steps_left)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (obs === exp) begin
         n_pass = n_pass + 1;
      end else begin
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a command for exactly one edge, then check the state right after acceptance
   task automatic send(input logic up, input int cnt);
      cmd_up    = up;
      cmd_count = 8'(cnt);
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      check("acc_steps", 32'(steps_left), cnt);
      check("acc_busy",  32'(busy),       32'(cnt != 0));
      check("acc_ready", 32'(cmd_ready),  32'(cnt == 0));
      check("acc_done",  32'(done),       32'(cnt == 0));
      check("acc_ab",    32'({a, b}),     32'd0);
   endtask

   // Follow a command cycle by cycle from its accepting edge (k = 0)
   task automatic observe(input logic up, input int count);
      int last;
      logic [1:0] exp_ab;
      last = count * 16;
      for (int k = 1; k <= last + 4; k++) begin
         tick();
         if (k >= last) exp_ab = 2'b00;
         else if (up)   exp_ab = up_seq[(k / 4) % 4];
         else           exp_ab = dn_seq[(k / 4) % 4];
         check("ab",    32'({a, b}),      32'(exp_ab));
         check("steps", 32'(steps_left),  (k >= last) ? 0 : count - (k / 16));
         check("done",  32'(done),        32'(k == last));
         check("busy",  32'(busy),        32'(k < last + 4));
         check("ready", 32'(cmd_ready),   32'(k >= last + 4));
      end
   endtask

   // Gray-property check and detent decoding on every falling edge
   always @(negedge clk) begin
      logic dir;
      if (rst) begin
         prev_ab <= {a, b};
      end else begin
         check("gray", 32'((prev_ab ^ {a, b}) != 2'b11), 32'd1);
         if (({a, b} == 2'b00) && ((prev_ab == 2'b01) || (prev_ab == 2'b10))) begin
            dir = (prev_ab == 2'b01);
            if (dir) dec_up <= dec_up + 1;
            else     dec_dn <= dec_dn + 1;
            if (have_dir && (dir != last_dir)) dec_dirch <= dec_dirch + 1;
            have_dir <= 1'b1;
            last_dir <= dir;
            dec_seq  <= {dec_seq[14:0], dir};
         end
         prev_ab <= {a, b};
      end
   end

   initial begin
      int up0, dn0, dc0;

      // Reset values, while reset is held and just after release
      tick();
      check("rst_ab",    32'({a, b}),     32'd0);
      check("rst_busy",  32'(busy),       32'd0);
      check("rst_done",  32'(done),       32'd0);
      check("rst_steps", 32'(steps_left), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      check("rst_ready", 32'(cmd_ready), 32'd1);

      // Up, one detent: 10@4 11@8 01@12 00@16, done@16, ready@20
      send(1'b1, 1);
      observe(1'b1, 1);

      // Down, two detents: steps_left 2 -> 1@16 -> 0@32
      send(1'b0, 2);
      observe(1'b0, 2);

      // Count zero: done on the next cycle only, busy never high
      send(1'b1, 0);
      tick();
      check("z_done", 32'(done),      32'd0);
      check("z_busy", 32'(busy),      32'd0);
      check("z_ab",   32'({a, b}),    32'd0);
      check("z_rdy",  32'(cmd_ready), 32'd1);

      // New command held valid while busy is ignored until the first ready
      cmd_up    = 1'b1;
      cmd_count = 8'd1;
      cmd_valid = 1'b1;
      tick();
      check("h_steps", 32'(steps_left), 32'd1);
      cmd_up    = 1'b0;
      cmd_count = 8'd2;
      observe(1'b1, 1);
      tick();
      cmd_valid = 1'b0;
      check("h2_steps", 32'(steps_left), 32'd2);
      check("h2_busy",  32'(busy),       32'd1);
      observe(1'b0, 2);

      // Reset at cycle 9 of an up run while {a,b} = 11
      send(1'b1, 1);
      repeat (8) tick();
      check("pre_rst_ab", 32'({a, b}), 32'b11);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_ab",    32'({a, b}),     32'd0);
      check("mid_rst_busy",  32'(busy),       32'd0);
      check("mid_rst_done",  32'(done),       32'd0);
      check("mid_rst_steps", 32'(steps_left), 32'd0);
      repeat (2) begin
         tick();
         check("rst_no_done", 32'(done), 32'd0);
      end
      rst = 1'b0;
      tick();
      check("post_rst_ready", 32'(cmd_ready), 32'd1);
      check("post_rst_done",  32'(done),      32'd0);
      send(1'b1, 1);
      observe(1'b1, 1);

      // Loopback: five detents up, then five down
      up0 = dec_up;
      dn0 = dec_dn;
      dc0 = dec_dirch;
      send(1'b1, 5);
      observe(1'b1, 5);
      send(1'b0, 5);
      observe(1'b0, 5);
      tick();
      check("dec_up",    dec_up - up0,         32'd5);
      check("dec_dn",    dec_dn - dn0,         32'd5);
      check("dec_dirch", dec_dirch - dc0,      32'd1);
      check("dec_seq",   32'(dec_seq[9:0]),    32'b1111100000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
